// File: rtl/universal_reg.sv
// ---------------------------------------------------------------------------
// universal_reg
//   WIDTH-bit general-purpose register: storage, parallel load, shift,
//   rotate, increment and decrement, with synchronous reset, clear and preset.
//   Serial pins allow several instances to be chained into a wider register.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset, loads RESET_VAL
//   en    operation enable (clr/set act regardless of en)
//   clr   synchronous clear to zero (beats set)
//   set   synchronous preset to PRESET_VAL
//   mode  operation select: 000 hold, 001 load, 010 shl, 011 shr,
//         100 rol, 101 ror, 110 inc, 111 dec
//   d     parallel load data
//   sil   serial in for shift-left (enters bit 0)
//   sir   serial in for shift-right (enters bit WIDTH-1)
//   q     register contents
//   qbar  ~q
//   sol   q[WIDTH-1], feeds the next stage's sil
//   sor   q[0], feeds the previous stage's sir
//   tc    terminal count: all-ones while incrementing, zero while
//         decrementing; independent of en so the next stage can use tc & en
// ---------------------------------------------------------------------------
module universal_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             set,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sol,
    output logic             sor,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;

    // Move every bit one place towards the MSB; 'fill' enters bit 0.
    // Written as a loop so WIDTH=1 degenerates cleanly to q <= fill.
    function automatic logic [WIDTH-1:0] move_up(input logic [WIDTH-1:0] v,
                                                 input logic             fill);
        logic [WIDTH-1:0] r;
        r[0] = fill;
        for (int i = 1; i < WIDTH; i++) begin
            r[i] = v[i-1];
        end
        return r;
    endfunction

    // Move every bit one place towards the LSB; 'fill' enters bit WIDTH-1.
    function automatic logic [WIDTH-1:0] move_down(input logic [WIDTH-1:0] v,
                                                   input logic             fill);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = fill;
        for (int i = 0; i < WIDTH - 1; i++) begin
            r[i] = v[i+1];
        end
        return r;
    endfunction

    // Next-state selection, highest priority first.
    always_comb begin
        next_s = q_r;
        if (rst) begin
            next_s = RESET_VAL;
        end else if (clr) begin
            next_s = ALL_ZERO;
        end else if (set) begin
            next_s = PRESET_VAL;
        end else if (en) begin
            case (mode)
                3'b000:  next_s = q_r;
                3'b001:  next_s = d;
                3'b010:  next_s = move_up(q_r, sil);
                3'b011:  next_s = move_down(q_r, sir);
                3'b100:  next_s = move_up(q_r, q_r[WIDTH-1]);
                3'b101:  next_s = move_down(q_r, q_r[0]);
                3'b110:  next_s = q_r + ONE;
                3'b111:  next_s = q_r - ONE;
                default: next_s = q_r;
            endcase
        end else begin
            next_s = q_r;
        end
    end

    // State register; rst is already folded into next_s with top priority.
    always_ff @(posedge clk) begin
        q_r <= next_s;
    end

    // Terminal count decode; looks only at mode and q, never at en.
    always_comb begin
        if ((mode == 3'b110) && (q_r == ALL_ONES)) begin
            tc = 1'b1;
        end else if ((mode == 3'b111) && (q_r == ALL_ZERO)) begin
            tc = 1'b1;
        end else begin
            tc = 1'b0;
        end
    end

    assign q    = q_r;
    assign qbar = ~q_r;
    assign sol  = q_r[WIDTH-1];
    assign sor  = q_r[0];

endmodule

// File: tb/tb_universal_reg.sv
module tb_universal_reg;

    logic clk;
    int   checks;
    int   failures;

    // 8-bit instance
    logic       rst, en, clr, set, sil, sir;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q, qbar;
    logic       sol, sor, tc;

    // cascade: two 4-bit stages
    logic       c_rst, c_en, c_clr, c_set, c_sil, c_cnt;
    logic [2:0] c_mode;
    logic [7:0] c_d;
    logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
    logic       lo_sol, lo_sor, lo_tc, hi_sol, hi_sor, hi_tc, hi_en;

    // 1-bit instance
    logic       w_rst, w_en, w_clr, w_set, w_sil, w_sir;
    logic [2:0] w_mode;
    logic [0:0] w_d, w_q, w_qbar;
    logic       w_sol, w_sor, w_tc;

    assign hi_en = c_cnt ? (lo_tc & c_en) : c_en;

    universal_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .set(set), .mode(mode),
        .d(d), .sil(sil), .sir(sir), .q(q), .qbar(qbar), .sol(sol),
        .sor(sor), .tc(tc)
    );

    universal_reg #(.WIDTH(4)) lo (
        .clk(clk), .rst(c_rst), .en(c_en), .clr(c_clr), .set(c_set),
        .mode(c_mode), .d(c_d[3:0]), .sil(c_sil), .sir(hi_sor),
        .q(lo_q), .qbar(lo_qbar), .sol(lo_sol), .sor(lo_sor), .tc(lo_tc)
    );

    universal_reg #(.WIDTH(4)) hi (
        .clk(clk), .rst(c_rst), .en(hi_en), .clr(c_clr), .set(c_set),
        .mode(c_mode), .d(c_d[7:4]), .sil(lo_sol), .sir(1'b0),
        .q(hi_q), .qbar(hi_qbar), .sol(hi_sol), .sor(hi_sor), .tc(hi_tc)
    );

    universal_reg #(.WIDTH(1)) w1 (
        .clk(clk), .rst(w_rst), .en(w_en), .clr(w_clr), .set(w_set),
        .mode(w_mode), .d(w_d), .sil(w_sil), .sir(w_sir), .q(w_q),
        .qbar(w_qbar), .sol(w_sol), .sor(w_sor), .tc(w_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model of the 8-bit register written as plain arithmetic.
    function automatic logic [7:0] model_next(input logic [7:0] cur,
        input logic r, input logic c, input logic s, input logic e,
        input logic [2:0] m, input logic [7:0] dd, input logic sl,
        input logic sr);
        int v;
        v = int'(cur);
        if (r)       return 8'h00;
        else if (c)  return 8'h00;
        else if (s)  return 8'hFF;
        else if (!e) return cur;
        case (m)
            3'd1:    v = int'(dd);
            3'd2:    v = (v * 2 + int'(sl)) % 256;
            3'd3:    v = v / 2 + 128 * int'(sr);
            3'd4:    v = (v * 2) % 256 + v / 128;
            3'd5:    v = v / 2 + 128 * (v % 2);
            3'd6:    v = (v + 1) % 256;
            3'd7:    v = (v + 255) % 256;
            default: v = int'(cur);
        endcase
        return 8'(v);
    endfunction

    function automatic logic model_tc(input logic [7:0] cur, input logic [2:0] m);
        return ((m == 3'd6) && (cur == 8'hFF)) || ((m == 3'd7) && (cur == 8'h00));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic s,
                         input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic sl, input logic sr);
        rst = r; clr = c; set = s; en = e; mode = m; d = dd; sil = sl; sir = sr;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if ({q, qbar, sol, sor, tc} !== {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: got q=%h qbar=%h sol=%b sor=%b tc=%b expected q=00 qbar=ff 0 0 0",
                     q, qbar, sol, sor, tc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if (q !== 8'hFF) begin
            failures++;
            $display("FAIL preset: got q=%h expected ff", q);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("FAIL clr_beats_set: got q=%h expected 00", q);
        end
    endtask

    task automatic test_load_hold();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        step();
        checks++;
        if ({q, qbar} !== {8'hA5, 8'h5A}) begin
            failures++;
            $display("FAIL load: got q=%h qbar=%h expected a5 5a", q, qbar);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== 8'hA5) begin
                failures++;
                $display("FAIL hold_en0[%0d]: got q=%h expected a5", i, q);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0);
        step();
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("FAIL clr_en0: got q=%h expected 00", q);
        end
    endtask

    task automatic test_shift_rotate();
        logic [2:0] modes [6];
        logic       sils  [6];
        logic       sirs  [6];
        logic [7:0] exps  [6];
        modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
        sils  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        sirs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exps  = '{8'h81, 8'h02, 8'h81, 8'h03, 8'h81, 8'hC0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, modes[i], 8'h81, sils[i], sirs[i]);
            step();
            checks++;
            if ({q, sol, sor} !== {exps[i], exps[i][7], exps[i][0]}) begin
                failures++;
                $display("FAIL shift_rotate[%0d]: got q=%h sol=%b sor=%b expected q=%h sol=%b sor=%b",
                         i, q, sol, sor, exps[i], exps[i][7], exps[i][0]);
            end
        end
    endtask

    task automatic test_count_wrap();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'hFE, 1'b0, 1'b0);
        step();
        mode = 3'd6;
        #1;
        checks++;
        if ({q, tc} !== {8'hFE, 1'b0}) begin
            failures++;
            $display("FAIL count_fe: got q=%h tc=%b expected fe 0", q, tc);
        end
        step();
        checks++;
        if ({q, tc} !== {8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL count_ff: got q=%h tc=%b expected ff 1", q, tc);
        end
        step();
        checks++;
        if ({q, tc} !== {8'h00, 1'b0}) begin
            failures++;
            $display("FAIL count_wrap: got q=%h tc=%b expected 00 0", q, tc);
        end
        mode = 3'd7;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            failures++;
            $display("FAIL dec_tc_zero: got tc=%b expected 1", tc);
        end
        step();
        checks++;
        if ({q, tc} !== {8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL dec_wrap: got q=%h tc=%b expected ff 0", q, tc);
        end
    endtask

    task automatic test_reset_mid_count();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (q !== 8'h05) begin
            failures++;
            $display("FAIL count_to_5: got q=%h expected 05", q);
        end
        rst = 1'b1;
        step();
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_count: got q=%h expected 00", q);
        end
        rst = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++;
            if (q !== 8'(i)) begin
                failures++;
                $display("FAIL resume_count[%0d]: got q=%h expected %h", i, q, 8'(i));
            end
        end
    endtask

    task automatic test_cascade();
        logic [7:0] comb;
        c_rst = 1'b0; c_clr = 1'b0; c_set = 1'b0; c_cnt = 1'b0; c_sil = 1'b0;
        c_en = 1'b1; c_mode = 3'd1; c_d = 8'h96;
        step();
        comb = {hi_q, lo_q};
        checks++;
        if (comb !== 8'h96) begin
            failures++;
            $display("FAIL cascade_load: got %h expected 96", comb);
        end
        c_mode = 3'd2; c_sil = 1'b1;
        step();
        comb = {hi_q, lo_q};
        checks++;
        if ({comb, ~{hi_qbar, lo_qbar}, hi_sol, lo_sor} !== {8'h2D, 8'h2D, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL cascade_shl: got %h qbarinv=%h sol=%b sor=%b expected 2d 2d 0 1",
                     comb, ~{hi_qbar, lo_qbar}, hi_sol, lo_sor);
        end
        c_mode = 3'd1; c_d = 8'h0F;
        step();
        c_mode = 3'd6; c_cnt = 1'b1;
        step();
        comb = {hi_q, lo_q};
        checks++;
        if ({comb, hi_tc} !== {8'h10, 1'b0}) begin
            failures++;
            $display("FAIL cascade_inc: got %h hi_tc=%b expected 10 0", comb, hi_tc);
        end
        // long run of cascaded counting compared against 8-bit arithmetic
        for (int i = 0; i < 300; i++) begin
            c_en = ($urandom_range(0, 3) != 0);
            c_mode = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7;
            #1;
            comb = {hi_q, lo_q};
            if (c_en) comb = (c_mode == 3'd6) ? 8'(comb + 8'd1) : 8'(comb - 8'd1);
            step();
            checks++;
            if ({hi_q, lo_q} !== comb) begin
                failures++;
                $display("FAIL cascade_count[%0d]: got %h expected %h", i, {hi_q, lo_q}, comb);
            end
        end
    endtask

    task automatic test_width1();
        // columns: mode, sil, sir, expected q after the edge, starting from q=0
        logic [2:0] m [8];
        logic       sl [8];
        logic       sr [8];
        logic       ex [8];
        m  = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        sl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        w_rst = 1'b1; w_en = 1'b1; w_clr = 1'b0; w_set = 1'b0;
        w_mode = 3'd0; w_d = 1'b0; w_sil = 1'b0; w_sir = 1'b0;
        step();
        w_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_mode = m[i]; w_sil = sl[i]; w_sir = sr[i];
            #1;
            checks++;
            if (w_tc !== ((m[i] == 3'd6 && w_q[0]) || (m[i] == 3'd7 && !w_q[0]))) begin
                failures++;
                $display("FAIL w1_tc[%0d]: got %b with q=%b mode=%0d", i, w_tc, w_q[0], m[i]);
            end
            step();
            checks++;
            if ({w_q[0], w_qbar[0], w_sol, w_sor} !== {ex[i], ~ex[i], ex[i], ex[i]}) begin
                failures++;
                $display("FAIL w1[%0d]: got q=%b qbar=%b sol=%b sor=%b expected q=%b",
                         i, w_q[0], w_qbar[0], w_sol, w_sor, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] mq;
        logic       r, c, s, e;
        logic [2:0] m;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step();
        mq = 8'h00;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 31) == 0);
            c = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 4) != 0);
            m = 3'($urandom_range(0, 7));
            drive(r, c, s, e, m, 8'($urandom), 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (tc !== model_tc(mq, m)) begin
                failures++;
                $display("FAIL rand_tc[%0d]: got %b expected %b (q=%h mode=%0d)",
                         i, tc, model_tc(mq, m), mq, m);
            end
            mq = model_next(mq, r, c, s, e, m, d, sil, sir);
            step();
            checks++;
            if ({q, qbar, sol, sor} !== {mq, ~mq, mq[7], mq[0]}) begin
                failures++;
                $display("FAIL rand_q[%0d]: got q=%h qbar=%h sol=%b sor=%b expected q=%h",
                         i, q, qbar, sol, sor, mq);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        c_rst = 1'b1; c_en = 1'b0; c_clr = 1'b0; c_set = 1'b0; c_sil = 1'b0;
        c_cnt = 1'b0; c_mode = 3'd0; c_d = 8'h00;
        w_rst = 1'b1; w_en = 1'b0; w_clr = 1'b0; w_set = 1'b0;
        w_mode = 3'd0; w_d = 1'b0; w_sil = 1'b0; w_sir = 1'b0;
        #3;
        test_reset();
        test_load_hold();
        test_shift_rotate();
        test_count_wrap();
        test_reset_mid_count();
        test_cascade();
        test_width1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/universal_reg.md
Name: universal_reg

Overview:
- Parametrised successor to the single-bit D storage element: a WIDTH-bit edge-triggered register with synchronous clear and preset.
- Adds mode-selected operation on top of plain storage: hold, parallel load, shift, rotate, increment and decrement.
- Serial in/out pins cascade instances into wider shift chains.
- Serves as the general-purpose register, shift register and counter element for the datapath.

Parameters:
- WIDTH, 8, register width in bits (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded by rst.
- PRESET_VAL, {WIDTH{1'b1}}, value loaded by set.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  operation enable; 0 = hold (clr/set still act)
- clr  input  1  synchronous clear to 0
- set  input  1  synchronous preset to PRESET_VAL
- mode  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sil  input  1  serial in for shift-left (enters bit 0)
- sir  input  1  serial in for shift-right (enters bit WIDTH-1)
- q  output  WIDTH  register contents
- qbar  output  WIDTH  always ~q
- sol  output  1  q[WIDTH-1] (feeds next stage's sil)
- sor  output  1  q[0] (feeds previous stage's sir)
- tc  output  1  terminal count (combinational)

Behaviour:
- Clock and reset: one clock domain. All state updates on posedge clk. rst is synchronous and active-high.
- Priority per edge: rst > clr > set > (en & mode) > hold.
  - rst: q <= RESET_VAL.
  - clr: q <= 0.
  - set: q <= PRESET_VAL.
  - clr and set together: clr wins. No invalid or metastable state, unlike a NAND pair with both inputs low.
- Reset values: q = RESET_VAL, qbar = ~RESET_VAL, sol/sor follow q, tc per the rule below.
- Mode encoding (applies only when en=1):
  - 000 hold.
  - 001 load: q <= d.
  - 010 shift left: q <= {q[WIDTH-2:0], sil}.
  - 011 shift right: q <= {sir, q[WIDTH-1:1]}.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 110 increment: q <= q+1 mod 2^WIDTH; wraps all-ones -> 0.
  - 111 decrement: q <= q-1 mod 2^WIDTH; wraps 0 -> all-ones.
- Latency: one cycle from the sampling edge to the new q. qbar, sol and sor are combinational from q, with no extra latency.
- tc:
  - 1 when mode=110 and q = all-ones.
  - 1 when mode=111 and q = 0.
  - Otherwise 0.
  - Independent of en, so a cascaded stage can use tc & en as its enable.
- WIDTH=1 boundaries:
  - Shift left: q <= sil.
  - Shift right: q <= sir.
  - Rotates: hold value.
  - Inc/dec: toggle.
- Mode changes take effect on the next edge; no internal state beyond q.
- Reset mid-operation (e.g. mid-count): q returns to RESET_VAL on that edge. Counting resumes from RESET_VAL on the following enabled edge.
- X/undefined mode values are not legal input. The RTL must use a full case with default = hold.

Test Plan:
- Reset/preset: RESET_VAL=8'h00, rst=1 for 1 edge -> q=00, qbar=FF. Then set=1 -> q=FF. Then set=1 with clr=1 -> q=00.
- Load/hold: en=1, mode=001, d=A5 -> q=A5 next edge. en=0 with mode=001, d=3C for 3 edges -> q stays A5. Assert clr with en=0 -> q=00.
- Shift/rotate: q=81.
  - mode=010, sil=0 -> 02.
  - mode=011, sir=1 -> 81.
  - mode=100 -> 03.
  - mode=101 twice -> 81 then C0.
  - sol/sor track q[7]/q[0] each cycle.
- Counting wrap: q=FE, mode=110.
  - tc=0 at FE; FF with tc=1; then 00 with tc=0.
  - Switch to mode=111 at q=00 -> tc=1, next q=FF.
- Cascade: two WIDTH=4 instances, low.sol->high.sil, high.sor->low.sir.
  - Load 8'h96 and shift left 1 with sil=1 -> combined 2D.
  - Increment with high.en = low.tc & en, from 0F -> 10.
- Reset mid-count: incrementing from 00, assert rst at q=05 -> q=00 next edge. Deassert rst -> 01, 02 on following edges.
